product_shift_register: RTL and testbench

Parametrised product/accumulator register for the sequential shift-add multiplier datapath. It holds a 2×WORD_LENGTH-bit word and supports load, clear, logical shifts and a conditional add-and-shift multiply step, with a built-in step counter that flags completion after WORD_LENGTH steps. It sits between the multiplier control FSM and the adder, and replaces the plain enable/sync-reset product register.

---
 rtl/product_shift_register.sv | 147 ++++++++++++++
 tb/tb_product_shift_register.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/product_shift_register.sv
// product_shift_register: 2*WORD_LENGTH-bit product/accumulator register for a shift-add multiplier.
//
// Holds the running product. Supports hold, parallel load, synchronous clear,
// logical shift right/left with a serial fill bit, and a conditional
// add-and-shift multiply step. A step counter saturates at WORD_LENGTH and
// raises count_done. Once it saturates, further multiply steps are ignored.
//
// Optional feature: define PRODUCT_SHIFT_REG_BOOTH_EN to enable op 101
// (radix-2 Booth step on signed operands) and the q_m1 history bit.
// Without the macro, op 101 behaves as HOLD.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   enable      1 = sync_clear/op take effect, 0 = hold all state
//   sync_clear  synchronous clear (qualified by enable), wins over op
//   op          3-bit operation select
//   data_in     parallel load value (WORD bits)
//   addend      multiplicand added into the upper half (WORD_LENGTH bits)
//   serial_in   fill bit for SHR/SHL
//   data_out    register contents
//   carry_out   bit shifted out by the most recent shift-type op
//   step_count  multiply steps since the last load/clear
//   count_done  step_count == WORD_LENGTH
module product_shift_register #(
    parameter int WORD_LENGTH = 4,
    parameter int WORD        = 2 * WORD_LENGTH,
    parameter int CNT_W       = $clog2(WORD_LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   sync_clear,
    input  logic [2:0]             op,
    input  logic [WORD-1:0]        data_in,
    input  logic [WORD_LENGTH-1:0] addend,
    input  logic                   serial_in,
    output logic [WORD-1:0]        data_out,
    output logic                   carry_out,
    output logic [CNT_W-1:0]       step_count,
    output logic                   count_done
);
    typedef enum logic [2:0] {
        OP_HOLD      = 3'b000,
        OP_LOAD      = 3'b001,
        OP_SHR       = 3'b010,
        OP_SHL       = 3'b011,
        OP_ADD_SHR   = 3'b100,
        OP_BOOTH_SHR = 3'b101
    } op_t;
    logic [WORD_LENGTH-1:0] upper;
    logic [WORD_LENGTH-1:0] lower;
    logic [WORD_LENGTH:0]   add_sum;
    logic [WORD-1:0]        data_nxt;
    logic                   carry_nxt;
    logic [CNT_W-1:0]       count_nxt;
    assign upper      = data_out[WORD-1:WORD_LENGTH];
    assign lower      = data_out[WORD_LENGTH-1:0];
    assign count_done = step_count == CNT_W'(WORD_LENGTH);
    // The extra sum bit is the adder carry; shifting {S, L} right drops it into the MSB.
    assign add_sum    = {1'b0, upper} + (data_out[0] ? {1'b0, addend} : '0);
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
    logic                   q_m1;
    logic                   q_m1_nxt;
    logic [WORD_LENGTH:0]   upper_sx;
    logic [WORD_LENGTH:0]   addend_sx;
    logic [WORD_LENGTH:0]   booth_sum;
    assign upper_sx  = {upper[WORD_LENGTH-1], upper};
    assign addend_sx = {addend[WORD_LENGTH-1], addend};
    // Pair {current LSB, previous LSB}: 01 ends a run of ones (add), 10 starts one (subtract).
    assign booth_sum = {data_out[0], q_m1} == 2'b01 ? upper_sx + addend_sx :
                       {data_out[0], q_m1} == 2'b10 ? upper_sx - addend_sx : upper_sx;
`endif
    always_comb begin
        data_nxt  = data_out;
        carry_nxt = carry_out;
        count_nxt = step_count;
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
        q_m1_nxt  = q_m1;
`endif
        if (sync_clear) begin
            data_nxt  = '0;
            carry_nxt = 1'b0;
            count_nxt = '0;
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
            q_m1_nxt  = 1'b0;
`endif
        end else begin
            case (op)
                OP_LOAD: begin
                    data_nxt  = data_in;
                    carry_nxt = 1'b0;
                    count_nxt = '0;
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
                    q_m1_nxt  = 1'b0;
`endif
                end
                OP_SHR: begin
                    data_nxt  = {serial_in, data_out[WORD-1:1]};
                    carry_nxt = data_out[0];
                end
                OP_SHL: begin
                    data_nxt  = {data_out[WORD-2:0], serial_in};
                    carry_nxt = data_out[WORD-1];
                end
                OP_ADD_SHR: begin
                    if (!count_done) begin
                        data_nxt  = {add_sum, lower[WORD_LENGTH-1:1]};
                        carry_nxt = data_out[0];
                        count_nxt = step_count + CNT_W'(1);
                    end
                end
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
                OP_BOOTH_SHR: begin
                    // booth_sum already carries the sign in its MSB, so this is an arithmetic shift.
                    if (!count_done) begin
                        data_nxt  = {booth_sum, lower[WORD_LENGTH-1:1]};
                        carry_nxt = data_out[0];
                        q_m1_nxt  = data_out[0];
                        count_nxt = step_count + CNT_W'(1);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out   <= '0;
            carry_out  <= 1'b0;
            step_count <= '0;
        end else if (enable) begin
            data_out   <= data_nxt;
            carry_out  <= carry_nxt;
            step_count <= count_nxt;
        end
    end
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_m1 <= 1'b0;
        else if (enable)
            q_m1 <= q_m1_nxt;
    end
`endif
endmodule

// File: tb/tb_product_shift_register.sv
// tb_product_shift_register: randomized and directed self-checking bench for product_shift_register.
module tb_product_shift_register;
    localparam int WL = 4;
    localparam int W  = 2 * WL;
    localparam int CW = $clog2(WL + 1);
    logic          clk;
    logic          reset;
    logic          enable;
    logic          sync_clear;
    logic [2:0]    op;
    logic [W-1:0]  data_in;
    logic [WL-1:0] addend;
    logic          serial_in;
    logic [W-1:0]  data_out;
    logic          carry_out;
    logic [CW-1:0] step_count;
    logic          count_done;
    int checks = 0;
    int failures = 0;
    int m_data, m_carry, m_cnt, m_q;
    product_shift_register #(.WORD_LENGTH(WL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sync_clear(sync_clear),
        .op(op), .data_in(data_in), .addend(addend), .serial_in(serial_in),
        .data_out(data_out), .carry_out(carry_out), .step_count(step_count),
        .count_done(count_done)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic int sx(input int v, input int bits);
        return v >= (1 << (bits - 1)) ? v - (1 << bits) : v;
    endfunction
    // Reference: the product register as an integer, split into upper/lower halves arithmetically.
    task automatic model_step();
        int hi, lo, s;
        if (!enable) return;
        hi = m_data >> WL;
        lo = m_data & ((1 << WL) - 1);
        if (sync_clear) begin
            m_data = 0; m_carry = 0; m_cnt = 0; m_q = 0;
        end else if (op == 3'd1) begin
            m_data = int'(data_in); m_carry = 0; m_cnt = 0; m_q = 0;
        end else if (op == 3'd2) begin
            m_carry = m_data & 1;
            m_data = (m_data >> 1) + (int'(serial_in) << (W - 1));
        end else if (op == 3'd3) begin
            m_carry = (m_data >> (W - 1)) & 1;
            m_data = ((m_data << 1) & ((1 << W) - 1)) + int'(serial_in);
        end else if (op == 3'd4 && m_cnt < WL) begin
            s = hi + ((m_data & 1) != 0 ? int'(addend) : 0);
            m_carry = m_data & 1;
            m_data = (s * (1 << (WL - 1)) + (lo >> 1)) & ((1 << W) - 1);
            m_cnt++;
        end
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
        else if (op == 3'd5 && m_cnt < WL) begin
            s = sx(hi, WL);
            if ((m_data & 1) == 1 && m_q == 0) s -= sx(int'(addend), WL);
            if ((m_data & 1) == 0 && m_q == 1) s += sx(int'(addend), WL);
            m_carry = m_data & 1;
            m_q = m_data & 1;
            m_data = (s * (1 << (WL - 1)) + (lo >> 1)) & ((1 << W) - 1);
            m_cnt++;
        end
`endif
    endtask
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic en, input logic clr, input logic [2:0] o,
                         input logic [W-1:0] d, input logic [WL-1:0] a, input logic si);
        enable = en; sync_clear = clr; op = o; data_in = d; addend = a; serial_in = si;
        cycle();
    endtask
    task automatic test_reset();
        reset = 1'b0;
        drive(1, 0, 3'd1, 8'hA5, 4'h3, 1'b1);
        repeat (2) cycle();
        m_data = 0; m_carry = 0; m_cnt = 0; m_q = 0;
        checks++;
        if ({data_out, carry_out, step_count, count_done} !== {W'(0), 1'b0, CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_state: got data=%h carry=%b cnt=%0d done=%b, want all zero",
                     data_out, carry_out, step_count, count_done);
        end
        reset = 1'b1;
    endtask
    task automatic test_async_reset();
        drive(1, 0, 3'd1, 8'h05, 4'h3, 0);
        drive(1, 0, 3'd4, 8'h00, 4'h3, 0);
        drive(1, 0, 3'd4, 8'h00, 4'h3, 0);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({data_out, carry_out, step_count, count_done} !== {W'(0), 1'b0, CW'(0), 1'b0}) begin
            failures++;
            $display("FAIL async_reset: got data=%h carry=%b cnt=%0d done=%b, want all zero before any edge",
                     data_out, carry_out, step_count, count_done);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        m_data = 0; m_carry = 0; m_cnt = 0; m_q = 0;
        drive(1, 0, 3'd1, 8'h3C, 4'h0, 0);
        checks++;
        if (data_out !== 8'h3C) begin
            failures++;
            $display("FAIL first_op_after_reset: got data=%h want 3c", data_out);
        end
    endtask
    task automatic test_hold();
        drive(1, 0, 3'd1, 8'h5A, 4'h0, 0);
        drive(1, 0, 3'd2, 8'h00, 4'h0, 1);
        drive(0, 1, 3'd1, 8'hFF, 4'h0, 0);
        drive(0, 0, 3'd4, 8'hFF, 4'hF, 0);
        checks++;
        if ({data_out, carry_out, step_count} !== {8'hAD, 1'b0, CW'(0)}) begin
            failures++;
            $display("FAIL enable_hold: got data=%h carry=%b cnt=%0d want data=ad carry=0 cnt=0",
                     data_out, carry_out, step_count);
        end
    endtask
    task automatic test_multiply();
        logic [W-1:0] exp_seq [4] = '{8'h1A, 8'h0D, 8'h1E, 8'h0F};
        drive(1, 0, 3'd1, 8'h05, 4'h3, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 3'd4, 8'h00, 4'h3, 0);
            checks++;
            if (data_out !== exp_seq[i] || step_count !== CW'(i + 1) || count_done !== (i == 3)) begin
                failures++;
                $display("FAIL mul_step%0d: got data=%h cnt=%0d done=%b want data=%h cnt=%0d done=%b",
                         i, data_out, step_count, count_done, exp_seq[i], i + 1, i == 3);
            end
        end
        drive(1, 0, 3'd4, 8'h00, 4'h3, 0);
        checks++;
        if (data_out !== 8'h0F || step_count !== CW'(4) || count_done !== 1'b1) begin
            failures++;
            $display("FAIL mul_saturate: got data=%h cnt=%0d done=%b want data=0f cnt=4 done=1",
                     data_out, step_count, count_done);
        end
    endtask
    task automatic test_carry_absorb();
        drive(1, 0, 3'd1, 8'h0F, 4'hF, 0);
        repeat (4) drive(1, 0, 3'd4, 8'h00, 4'hF, 0);
        checks++;
        if (data_out !== 8'hE1) begin
            failures++;
            $display("FAIL carry_absorb: got data=%h want e1", data_out);
        end
    endtask
    task automatic test_shifts();
        drive(1, 0, 3'd1, 8'h81, 4'h0, 0);
        drive(1, 0, 3'd3, 8'h00, 4'h0, 0);
        checks++;
        if (data_out !== 8'h02 || carry_out !== 1'b1) begin
            failures++;
            $display("FAIL shl: got data=%h carry=%b want data=02 carry=1", data_out, carry_out);
        end
        drive(1, 0, 3'd2, 8'h00, 4'h0, 1);
        checks++;
        if (data_out !== 8'h81 || carry_out !== 1'b0 || step_count !== CW'(0)) begin
            failures++;
            $display("FAIL shr: got data=%h carry=%b cnt=%0d want data=81 carry=0 cnt=0",
                     data_out, carry_out, step_count);
        end
    endtask
    task automatic test_sync_clear();
        drive(1, 0, 3'd1, 8'h07, 4'h5, 0);
        repeat (2) drive(1, 0, 3'd4, 8'h00, 4'h5, 0);
        drive(1, 1, 3'd4, 8'h00, 4'h5, 0);
        checks++;
        if (data_out !== 8'h00 || step_count !== CW'(0) || carry_out !== 1'b0) begin
            failures++;
            $display("FAIL sync_clear: got data=%h cnt=%0d carry=%b want 00/0/0",
                     data_out, step_count, carry_out);
        end
    endtask
    task automatic test_booth();
        drive(1, 0, 3'd1, 8'h0D, 4'h3, 0);
        repeat (4) drive(1, 0, 3'd5, 8'h00, 4'h3, 0);
        checks++;
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
        if (data_out !== 8'hF7 || count_done !== 1'b1) begin
            failures++;
            $display("FAIL booth: got data=%h done=%b want f7 done=1", data_out, count_done);
        end
`else
        if (data_out !== 8'h0D || step_count !== CW'(0)) begin
            failures++;
            $display("FAIL booth_disabled: got data=%h cnt=%0d want 0d cnt=0", data_out, step_count);
        end
`endif
    endtask
    task automatic test_random_products();
        int a, b, exp;
        for (int n = 0; n < 24; n++) begin
            a = $urandom_range(0, (1 << WL) - 1);
            b = $urandom_range(0, (1 << WL) - 1);
            drive(1, 0, 3'd1, W'(b), WL'(a), 0);
            repeat (WL) drive(1, 0, 3'd4, W'(0), WL'(a), 1'($urandom));
            checks++;
            if (int'(data_out) !== a * b) begin
                failures++;
                $display("FAIL product %0d*%0d: got %0d want %0d", a, b, data_out, a * b);
            end
`ifdef PRODUCT_SHIFT_REG_BOOTH_EN
            drive(1, 0, 3'd1, W'(b), WL'(a), 0);
            repeat (WL) drive(1, 0, 3'd5, W'(0), WL'(a), 0);
            exp = (sx(a, WL) * sx(b, WL)) & ((1 << W) - 1);
            checks++;
            if (int'(data_out) !== exp) begin
                failures++;
                $display("FAIL signed_product %0d*%0d: got %h want %h", sx(a, WL), sx(b, WL), data_out, exp);
            end
`else
            exp = 0;
`endif
        end
    endtask
    task automatic test_random_ops();
        logic [2:0] o;
        for (int n = 0; n < 400; n++) begin
            o = ($urandom_range(0, 9) < 4) ? 3'd4 : 3'($urandom);
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0, o,
                  W'($urandom), WL'($urandom), 1'($urandom));
            checks++;
            if ({data_out, carry_out, step_count, count_done} !==
                {W'(m_data), 1'(m_carry), CW'(m_cnt), m_cnt == WL}) begin
                failures++;
                $display("FAIL random_op%0d op=%0d: got data=%h carry=%b cnt=%0d done=%b want data=%h carry=%0d cnt=%0d done=%b",
                         n, o, data_out, carry_out, step_count, count_done,
                         W'(m_data), m_carry, m_cnt, m_cnt == WL);
            end
        end
    endtask
    initial begin
        reset = 1'b1; enable = 1'b0; sync_clear = 1'b0; op = 3'd0;
        data_in = '0; addend = '0; serial_in = 1'b0;
        m_data = 0; m_carry = 0; m_cnt = 0; m_q = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_hold();
        test_multiply();
        test_carry_absorb();
        test_shifts();
        test_sync_clear();
        test_booth();
        test_async_reset();
        test_random_products();
        test_random_ops();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
